sys_bus_master: RTL and testbench
=================================

Name: sys_bus_master

Overview:
- Initiator-side controller for the system bus: it drives the address-line and data-line bus strobes that the bus slices consume.
- Accepts one CPU/DMA request at a time over a valid/ready handshake.
- Sequences an address-latch (ALE) phase, then either a write phase or a multi-cycle read phase, and returns a one-cycle response carrying the read data.
- Sits between the core request port and the AL/DL bus slices.

Parameters:
- ADDR_W, 8, address width; equals the bus address width and memory depth index.
- DATA_W, 32, data width; equals the memory word width.
- RD_LATENCY, 2, number of cycles bus_read is held before read data is sampled. Legal range 2..15.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on the clk rising edge).
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- resp_valid  out  1  one-cycle completion pulse.
- resp_write  out  1  type of the completed transaction.
- resp_rdata  out  DATA_W  read data; 0 for writes.
- bus_ale  out  1  address latch enable to the address slice.
- bus_read  out  1  read enable to the address and data slices.
- bus_write  out  1  write enable to the data slice.
- bus_addr_out  out  ADDR_W  address driven to the address slice.
- bus_data_out  out  DATA_W  write data driven to the data slice.
- bus_data_in  in  DATA_W  read data returned from the data slice.
- busy  out  1  high whenever the state is not IDLE.
- txn_count  out  CNT_W  number of completed transactions.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - Every output is 0 except req_ready, which is 1.
  - Latched request and read counter are cleared.
  - An in-flight transaction is dropped with no resp_valid.
  - txn_count returns to 0.
- States: IDLE, ALE, WR, RD, DONE.
- IDLE:
  - req_ready=1.
  - Transfer occurs when req_valid=1 at a clock edge: latch req_addr, req_wdata and req_write; go to ALE.
  - req_ready is 0 in every other state; requests presented there are not accepted and must be held by the source.
- ALE (exactly 1 cycle):
  - bus_ale=1, bus_addr_out=latched address.
  - Next state is WR if write, otherwise RD.
- WR (exactly 1 cycle):
  - bus_write=1, bus_data_out=latched wdata.
  - Next state is DONE.
- RD (RD_LATENCY cycles):
  - bus_read=1 throughout; the read counter loads RD_LATENCY-1 on entry and decrements each cycle.
  - When the counter reaches 0, bus_data_in is captured into resp_rdata on the edge that leaves RD; next state is DONE.
- DONE (exactly 1 cycle):
  - resp_valid=1 and resp_write=latched type.
  - resp_rdata holds the captured data for reads and 0 for writes.
  - txn_count increments by 1; it wraps from 2^CNT_W-1 to 0 with no flag.
  - Next state is IDLE.
- Strobe encoding:
  - bus_ale, bus_read and bus_write are mutually exclusive; at most one is high in any cycle.
  - bus_addr_out is 0 outside ALE; bus_data_out is 0 outside WR.
- Throughput: a write occupies 4 cycles from acceptance edge to re-readiness (ALE, WR, DONE, IDLE); a read occupies 3+RD_LATENCY cycles.
- resp_valid and req_ready are never high in the same cycle.
- busy = (state != IDLE).
- Request changes: changes on req_* after acceptance have no effect on the transaction in flight.
- Reset mid-operation: applies in any state, including the last RD cycle. No capture occurs and no response is issued.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 -> req_ready=1, all strobes 0, resp_valid=0, txn_count=0; no transfer occurs.
- Single write (addr=8'h3C, wdata=32'hDEADBEEF):
  - Cycle after acceptance: bus_ale=1, bus_addr_out=8'h3C.
  - Next cycle: bus_write=1, bus_data_out=32'hDEADBEEF.
  - Next cycle: resp_valid=1, resp_write=1, resp_rdata=0.
  - Next cycle: req_ready=1, txn_count=1.
- Single read (addr=8'h3C, RD_LATENCY=2), data slice returns 32'hDEADBEEF one cycle after bus_read -> ALE for 1 cycle, bus_read=1 for exactly 2 cycles, then resp_valid=1 with resp_rdata=32'hDEADBEEF.
- Read with RD_LATENCY=5 -> bus_read held exactly 5 cycles; data sampled only at the end of the 5th cycle (changes on bus_data_in earlier are ignored).
- Back-to-back traffic: write then read with req_valid held high -> second request accepted only in the IDLE cycle after DONE; strobes never overlap; txn_count=2.
- Reset asserted during the second RD cycle -> next cycle all outputs at reset values, no resp_valid, txn_count=0.
- Wrap: CNT_W=2, run 5 writes -> txn_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sys_bus_if.sv
// Request/response handshake plus the AL/DL bus strobes between the initiator and the system.
interface sys_bus_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_write;
    logic [DATA_W-1:0] resp_rdata;
    logic              bus_ale;
    logic              bus_read;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr_out;
    logic [DATA_W-1:0] bus_data_out;
    logic [DATA_W-1:0] bus_data_in;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_data_in,
        output req_ready, resp_valid, resp_write, resp_rdata,
               bus_ale, bus_read, bus_write, bus_addr_out, bus_data_out
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_data_in,
        input  req_ready, resp_valid, resp_write, resp_rdata,
               bus_ale, bus_read, bus_write, bus_addr_out, bus_data_out
    );
endinterface

// File: rtl/sys_bus_master.sv
// System bus initiator: one request at a time, ALE phase then write or multi-cycle read,
// single-cycle response. Every output is a register.
module sys_bus_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 2,   // legal 2..15
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    sys_bus_if.master        bus,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);
    localparam int RCNT_W = 4;
    localparam logic [RCNT_W-1:0] RD_LOAD = RCNT_W'(RD_LATENCY - 1);

    typedef enum logic [2:0] {S_IDLE, S_ALE, S_WR, S_RD, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [RCNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]    txn_q, txn_d;

    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_write_q, resp_write_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                ale_q, ale_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_out_q, addr_out_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic                busy_q, busy_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req_valid) state_d = S_ALE;
            S_ALE:   state_d = write_q ? S_WR : S_RD;
            S_WR:    state_d = S_DONE;
            S_RD:    if (rd_cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        rd_cnt_d = rd_cnt_q;
        txn_d    = txn_q;
        if (state_q == S_IDLE && bus.req_valid) begin
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            write_d = bus.req_write;
        end
        if (state_q == S_ALE) rd_cnt_d = RD_LOAD;
        else if (state_q == S_RD && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - RCNT_W'(1);
        if (state_q == S_DONE) txn_d = txn_q + CNT_W'(1);
    end

    // Outputs are decoded from the next state so the registered strobes line up with the state.
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        ale_d        = (state_d == S_ALE);
        rd_d         = (state_d == S_RD);
        wr_d         = (state_d == S_WR);
        addr_out_d   = ale_d ? addr_d : '0;
        data_out_d   = wr_d ? wdata_q : '0;
        resp_valid_d = (state_d == S_DONE);
        resp_write_d = resp_valid_d & write_q;
        resp_rdata_d = (state_q == S_RD && state_d == S_DONE) ? bus.bus_data_in : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            rd_cnt_q     <= '0;
            txn_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_rdata_q <= '0;
            ale_q        <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_out_q   <= '0;
            data_out_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            rd_cnt_q     <= rd_cnt_d;
            txn_q        <= txn_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_write_q <= resp_write_d;
            resp_rdata_q <= resp_rdata_d;
            ale_q        <= ale_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_out_q   <= addr_out_d;
            data_out_q   <= data_out_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_write   = resp_write_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.bus_ale      = ale_q;
    assign bus.bus_read     = rd_q;
    assign bus.bus_write    = wr_q;
    assign bus.bus_addr_out = addr_out_q;
    assign bus.bus_data_out = data_out_q;
    assign busy             = busy_q;
    assign txn_count        = txn_q;
endmodule

// File: tb/tb_sys_bus_master.sv
// Scoreboard bench for sys_bus_master: three instances cover RD_LATENCY 2 and 5 and a 2-bit counter.
module tb_sys_bus_master;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [DATA_W-1:0] cur_rdata = '0;
    logic [DATA_W-1:0] data_in;
    logic [3:0]        rd_cnt = '0;
    int                sel = 0;

    sys_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if0 ();
    sys_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();
    sys_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if2 ();

    logic        busy0, busy1, busy2;
    logic [15:0] txn0, txn1;
    logic [1:0]  txn2;

    sys_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0), .busy(busy0), .txn_count(txn0));
    sys_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(5), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1), .busy(busy1), .txn_count(txn1));
    sys_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(if2), .busy(busy2), .txn_count(txn2));

    assign if0.req_valid = req_valid && (sel == 0);
    assign if1.req_valid = req_valid && (sel == 1);
    assign if2.req_valid = req_valid && (sel == 2);
    assign if0.req_write = req_write;
    assign if1.req_write = req_write;
    assign if2.req_write = req_write;
    assign if0.req_addr  = req_addr;
    assign if1.req_addr  = req_addr;
    assign if2.req_addr  = req_addr;
    assign if0.req_wdata = req_wdata;
    assign if1.req_wdata = req_wdata;
    assign if2.req_wdata = req_wdata;
    assign if0.bus_data_in = data_in;
    assign if1.bus_data_in = data_in;
    assign if2.bus_data_in = data_in;

    typedef struct packed {
        logic        ready;
        logic        resp_valid;
        logic        resp_write;
        logic [31:0] rdata;
        logic        ale;
        logic        rd;
        logic        wr;
        logic [7:0]  addr_out;
        logic [31:0] data_out;
        logic        busy;
        logic [15:0] txn;
    } obs_t;

    obs_t obs0, obs1, obs2, o;
    assign obs0 = {if0.req_ready, if0.resp_valid, if0.resp_write, if0.resp_rdata, if0.bus_ale,
                   if0.bus_read, if0.bus_write, if0.bus_addr_out, if0.bus_data_out, busy0, txn0};
    assign obs1 = {if1.req_ready, if1.resp_valid, if1.resp_write, if1.resp_rdata, if1.bus_ale,
                   if1.bus_read, if1.bus_write, if1.bus_addr_out, if1.bus_data_out, busy1, txn1};
    assign obs2 = {if2.req_ready, if2.resp_valid, if2.resp_write, if2.resp_rdata, if2.bus_ale,
                   if2.bus_read, if2.bus_write, if2.bus_addr_out, if2.bus_data_out, busy2,
                   {14'd0, txn2}};
    assign o = (sel == 1) ? obs1 : (sel == 2) ? obs2 : obs0;

    int          lat_sel;
    logic [15:0] txn_mask;
    assign lat_sel  = (sel == 1) ? 5 : 2;
    assign txn_mask = (sel == 2) ? 16'h0003 : 16'hFFFF;

    // Data slice model: only the last RD cycle carries the real word, earlier cycles carry junk.
    always @(posedge clk) rd_cnt <= o.rd ? rd_cnt + 4'd1 : 4'd0;
    assign data_in = (o.rd && rd_cnt == 4'(lat_sel - 1)) ? cur_rdata
                                                          : (~cur_rdata ^ {28'd0, rd_cnt});

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [31:0] rdata;
    } resp_t;

    resp_t       sb[$];
    resp_t       popped;
    logic [15:0] exp_txn [3];
    bit          txn_pend = 1'b0;

    initial foreach (exp_txn[i]) exp_txn[i] = '0;

    always @(clk) begin
        if (clk) begin
            if (!rst) begin
                sb.delete();
                foreach (exp_txn[i]) exp_txn[i] = '0;
                txn_pend = 1'b0;
            end
        end else if (rst) begin
            if (txn_pend) begin
                check("txn_count", o.txn, exp_txn[sel]);
                txn_pend = 1'b0;
            end
            check("strobe_excl", ($countones({o.ale, o.rd, o.wr}) <= 1), 1);
            check("resp_vs_ready", o.resp_valid & o.ready, 0);
            check("busy_vs_ready", o.busy, !o.ready);
            if (!o.ale) check("addr_idle", o.addr_out, 0);
            if (!o.wr)  check("data_idle", o.data_out, 0);
            if (o.resp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_resp", 1, 0);
                end else begin
                    popped = sb.pop_front();
                    check("resp_write", o.resp_write, popped.write);
                    check("resp_rdata", o.rdata, popped.rdata);
                end
                exp_txn[sel] = (exp_txn[sel] + 16'd1) & txn_mask;
                txn_pend = 1'b1;
            end
        end
    end

    task automatic check_reset_vals(input string t);
        check({t, "_ready"}, o.ready, 1);
        check({t, "_strobes"}, {o.ale, o.rd, o.wr}, 0);
        check({t, "_resp_valid"}, o.resp_valid, 0);
        check({t, "_rdata"}, o.rdata, 0);
        check({t, "_addr_out"}, o.addr_out, 0);
        check({t, "_data_out"}, o.data_out, 0);
        check({t, "_busy"}, o.busy, 0);
        check({t, "_txn"}, o.txn, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", o.ready, 1);
    endtask

    // Presents one request at a negedge; returns at the first negedge where req_ready is back.
    task automatic issue(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                         input bit hold);
        int    n;
        int    rd_cycles;
        resp_t r;
        wait_ready();
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = data;
        if (!wr) cur_rdata = data;
        r.write = wr;
        r.rdata = wr ? 32'h0 : data;
        sb.push_back(r);
        @(negedge clk);
        req_valid = hold;
        req_write = ~wr;
        req_addr  = ~addr;
        req_wdata = ~data;
        check("ale", o.ale, 1);
        check("ale_addr", o.addr_out, addr);
        n = 1;
        rd_cycles = 0;
        do begin
            @(negedge clk);
            n++;
            if (o.rd) rd_cycles++;
            if (wr && n == 2) begin
                check("wr_strobe", o.wr, 1);
                check("wr_data", o.data_out, data);
            end
        end while (!o.ready && n < 40);
        check("occupancy", n, wr ? 4 : 3 + lat_sel);
        check("rd_cycles", rd_cycles, wr ? 0 : lat_sel);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held for three edges with a request pending: nothing may be accepted.
        sel       = 0;
        rst       = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h3C;
        req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("no_xfer_busy", o.busy, 0);

        issue(1'b1, 8'h3C, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 8'h3C, 32'hDEAD_BEEF, 1'b0);
        issue(1'b1, 8'h00, 32'h0000_0000, 1'b0);
        issue(1'b0, 8'hFF, 32'h1234_5678, 1'b0);
        issue(1'b1, 8'h81, 32'hCAFE_F00D, 1'b1);
        issue(1'b0, 8'h81, 32'h0BAD_F00D, 1'b0);
        @(negedge clk);

        // Reset in the last RD cycle: no capture, no response, counter cleared.
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h55;
        req_wdata = 32'h0;
        cur_rdata = 32'h1357_9BDF;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_ale", o.ale, 1);
        @(negedge clk);
        check("mid_rd1", o.rd, 1);
        @(negedge clk);
        check("mid_rd2", o.rd, 1);
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_rst");
        rst = 1'b1;
        repeat (6) @(negedge clk);

        sel = 1;
        @(negedge clk);
        issue(1'b0, 8'h10, 32'hA5A5_5A5A, 1'b0);
        issue(1'b1, 8'h20, 32'h7777_0001, 1'b0);
        issue(1'b0, 8'hEE, 32'h0F0F_F0F0, 1'b0);
        @(negedge clk);

        sel = 2;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 8'(i), 32'h1000_0000 + 32'(i), 1'b0);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
